// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared RISC-V definitions for the branch resolve slice.
//   OPC_BRANCH  : conditional branch major opcode (inst[6:0])
//   F3_*        : funct3 encodings of the six conditional branches
//   bru_state_t : branch resolve unit control states
//   branch_imm  : B-type immediate extraction, sign-extended to 32 bits
package riscv_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } bru_state_t;

    // {inst[31], inst[7], inst[30:25], inst[11:8], 0}, sign-extended.
    function automatic logic [31:0] branch_imm(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// branch_cmp -- combinational branch condition evaluator.
//   funct3  : branch comparison selector
//   rs1/rs2 : operands
//   taken   : condition holds (always 0 for reserved encodings)
//   illegal : funct3 is 010 or 011 (no branch defined)
module branch_cmp
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        taken,
    output logic        illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit -- resolves conditional branches one per cycle and
// squashes younger instructions for FLUSH_CYCLES cycles after a taken one.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : upstream handshake (inst, pc, rs1_data, rs2_data)
//   out_valid/out_ready   : downstream handshake to the PC-select stage
//   out_inst              : registered copy of the accepted instruction
//   out_taken/out_target  : branch decision and next PC (pc+imm or pc+4)
//   out_illegal           : branch opcode with reserved funct3
//   out_misalign          : taken branch whose target has bit 1 set
//   flush                 : squash indication to fetch/decode
module branch_resolve_unit
    import riscv_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_taken,
    output logic [31:0] out_target,
    output logic        out_illegal,
    output logic        out_misalign,
    output logic        flush
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    bru_state_t  state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;

    logic        accept;
    logic        is_branch;
    logic        cmp_taken;
    logic        cmp_illegal;
    logic        taken;
    logic        illegal;
    logic [31:0] target;

    branch_cmp u_cmp (
        .funct3  (inst[14:12]),
        .rs1     (rs1_data),
        .rs2     (rs2_data),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    assign is_branch = (inst[6:0] == OPC_BRANCH);
    assign taken     = is_branch & cmp_taken;
    assign illegal   = is_branch & cmp_illegal;
    assign target    = taken ? (pc + branch_imm(inst)) : (pc + 32'd4);

    // Gated by rst_n so every output reads 0 while reset is held.
    assign in_ready  = rst_n & (~out_valid | out_ready);
    assign accept    = in_valid & in_ready;
    assign flush     = (state == ST_FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Flush entry depends only on acceptance, so a stalled taken result
    // never postpones it; branches accepted during FLUSH are ignored here.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_RUN: begin
                if (accept && taken) begin
                    state_nxt = ST_FLUSH;
                    cnt_nxt   = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (cnt <= 4'd1) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
        endcase
    end

    // Accepting implies the slot is empty or being consumed, so a squashed
    // accept simply leaves the register empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_inst     <= '0;
            out_taken    <= 1'b0;
            out_target   <= '0;
            out_illegal  <= 1'b0;
            out_misalign <= 1'b0;
        end else if (accept && state == ST_RUN) begin
            out_valid    <= 1'b1;
            out_inst     <= inst;
            out_taken    <= taken;
            out_target   <= target;
            out_illegal  <= illegal;
            out_misalign <= taken & target[1];
        end else if (accept || out_ready) begin
            out_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    localparam int unsigned FC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_taken;
    logic [31:0] out_target;
    logic        out_illegal;
    logic        out_misalign;
    logic        flush;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic        taken;
        logic [31:0] target;
        logic        illegal;
        logic        misalign;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    branch_resolve_unit #(.FLUSH_CYCLES(FC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .inst         (inst),
        .pc           (pc),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_inst     (out_inst),
        .out_taken    (out_taken),
        .out_target   (out_target),
        .out_illegal  (out_illegal),
        .out_misalign (out_misalign),
        .flush        (flush)
    );

    // Encode a B-type instruction from funct3 and a byte offset.
    function automatic logic [31:0] mk_b(input logic [2:0] f3, input int imm);
        logic [12:0] i;
        i = imm[12:0];
        return {i[12], i[10:5], 5'd0, 5'd0, f3, i[4:1], i[11], 7'b1100011};
    endfunction

    // Reference model: works from the intended offset, not the encoding.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input int imm);
        exp_t e;
        logic t;
        logic ill;
        t   = 1'b0;
        ill = 1'b0;
        if (ins[6:0] == 7'b1100011) begin
            case (ins[14:12])
                3'd0:    t = (a == b);
                3'd1:    t = (a != b);
                3'd4:    t = (int'(a) <  int'(b));
                3'd5:    t = (int'(a) >= int'(b));
                3'd6:    t = (a <  b);
                3'd7:    t = (a >= b);
                default: ill = 1'b1;
            endcase
        end
        e.inst     = ins;
        e.taken    = t;
        e.illegal  = ill;
        e.target   = t ? (p + 32'(imm)) : (p + 32'd4);
        e.misalign = t && e.target[1];
        return e;
    endfunction

    // Scoreboard: every consumed result is compared with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: got out_valid=1 inst=%h, required no output", out_inst);
            end else begin
                e = sb.pop_front();
                if ({out_inst, out_taken, out_target, out_illegal, out_misalign} !== e) begin
                    n_fail++;
                    $display("FAIL result: got inst=%h taken=%b target=%h ill=%b mis=%b, required inst=%h taken=%b target=%h ill=%b mis=%b",
                             out_inst, out_taken, out_target, out_illegal, out_misalign,
                             e.inst, e.taken, e.target, e.illegal, e.misalign);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b,
                        input int imm, input bit present,
                        output int waited, output logic fl);
        inst     = i;
        pc       = p;
        rs1_data = a;
        rs2_data = b;
        in_valid = 1'b1;
        waited   = 0;
        fl       = 1'b0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                fl = flush;
                if (present) sb.push_back(model(i, p, a, b, imm));
                break;
            end
            waited++;
            if (waited > 20) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required accept", waited);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        inst = '0; pc = '0; rs1_data = '0; rs2_data = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b, required 0", in_ready);
        end
        n_checks++;
        if ({out_valid, flush, out_taken, out_illegal, out_misalign} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got v/f/t/i/m=%b%b%b%b%b, required 00000",
                               out_valid, flush, out_taken, out_illegal, out_misalign);
        end
        n_checks++;
        if ({out_inst, out_target} !== 64'd0) begin
            n_fail++; $display("FAIL reset_data: got inst=%h target=%h, required 0", out_inst, out_target);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL release_in_ready: got %b, required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_beq_flush;
        int w; logic fl;
        send(mk_b(3'd0, 16), 32'h100, 32'd5, 32'd5, 16, 1'b1, w, fl);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (flush !== (k < int'(FC))) begin
                n_fail++; $display("FAIL beq_flush_cycle%0d: got %b, required %b", k, flush, (k < int'(FC)));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_compare;
        logic [2:0]  f3s[9] = '{3'd4, 3'd6, 3'd1, 3'd5, 3'd7, 3'd0, 3'd2, 3'd3, 3'd1};
        logic [31:0] as[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'd1, 32'd1, 32'd1, 32'd7, 32'd7, 32'd8};
        logic [31:0] bs[9]  = '{32'd1, 32'd1, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd7, 32'd7, 32'd9};
        int          imms[9] = '{32, 32, -8, 12, 20, 40, 16, 16, 6};
        int w; logic fl;
        for (int k = 0; k < 9; k++) begin
            send(mk_b(f3s[k], imms[k]), 32'h200 + 32'(k * 64), as[k], bs[k], imms[k], 1'b1, w, fl);
            idle(FC + 1);
        end
        send(32'h00000013, 32'h300, 32'd1, 32'd1, 0, 1'b1, w, fl);
        idle(2);
    endtask

    task automatic test_wrap;
        int w; logic fl;
        send(mk_b(3'd0, 8), 32'hFFFFFFFC, 32'd9, 32'd9, 8, 1'b1, w, fl);
        idle(FC + 1);
        send(32'h00100093, 32'hFFFFFFFC, 32'd0, 32'd0, 0, 1'b1, w, fl);
        idle(2);
    endtask

    task automatic test_back_to_back;
        int w; logic fl;
        out_ready = 1'b0;
        send(32'h00500093, 32'h400, 32'd0, 32'd0, 0, 1'b1, w, fl);
        inst = 32'h00600113; pc = 32'h404; rs1_data = '0; rs2_data = '0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_in_ready%0d: got %b, required 0", k, in_ready);
            end
            n_checks++;
            if ({out_valid, out_inst, out_target, out_taken} !== {1'b1, 32'h00500093, 32'h404, 1'b0}) begin
                n_fail++; $display("FAIL stall_hold%0d: got v=%b inst=%h target=%h, required v=1 inst=00500093 target=00000404",
                                   k, out_valid, out_inst, out_target);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h00600113, 32'h404, 32'd0, 32'd0, 0, 1'b1, w, fl);
        n_checks++;
        if (w != 0) begin n_fail++; $display("FAIL b2b_first: got wait=%0d, required 0", w); end
        send(32'h00700193, 32'h408, 32'd0, 32'd0, 0, 1'b1, w, fl);
        n_checks++;
        if (w != 0) begin n_fail++; $display("FAIL b2b_second: got wait=%0d, required 0", w); end
        send(32'h00800213, 32'h40C, 32'd0, 32'd0, 0, 1'b1, w, fl);
        n_checks++;
        if (w != 0) begin n_fail++; $display("FAIL b2b_third: got wait=%0d, required 0", w); end
        idle(2);
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_flush_squash;
        int w; logic fl;
        send(mk_b(3'd0, 32), 32'h500, 32'd1, 32'd1, 32, 1'b1, w, fl);
        n_checks++;
        if (fl !== 1'b0) begin n_fail++; $display("FAIL squash_pre: got flush=%b, required 0", fl); end
        send(32'h00900293, 32'h504, 32'd0, 32'd0, 0, 1'b0, w, fl);
        n_checks++;
        if (fl !== 1'b1) begin n_fail++; $display("FAIL squash_first: got flush=%b, required 1", fl); end
        send(mk_b(3'd0, 64), 32'h508, 32'd2, 32'd2, 64, 1'b0, w, fl);
        n_checks++;
        if (fl !== 1'b1) begin n_fail++; $display("FAIL squash_second: got flush=%b, required 1", fl); end
        send(32'h00A00313, 32'h50C, 32'd0, 32'd0, 0, 1'b1, w, fl);
        n_checks++;
        if (fl !== 1'b0) begin n_fail++; $display("FAIL squash_third: got flush=%b, required 0", fl); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (flush !== 1'b0) begin n_fail++; $display("FAIL no_reflush%0d: got %b, required 0", k, flush); end
        end
        idle(1);
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL squash_drain: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_reset_midflush;
        int w; logic fl;
        out_ready = 1'b0;
        send(mk_b(3'd1, 24), 32'h600, 32'd1, 32'd2, 24, 1'b1, w, fl);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({flush, out_valid, in_ready, out_taken} !== 4'b0) begin
            n_fail++; $display("FAIL midflush_reset: got f/v/r/t=%b%b%b%b, required 0000", flush, out_valid, in_ready, out_taken);
        end
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midflush_release: got in_ready=%b, required 1", in_ready); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(mk_b(3'd4, 48), 32'h700, 32'd5, 32'd3, 48, 1'b1, w, fl);
        n_checks++;
        if (fl !== 1'b0) begin n_fail++; $display("FAIL post_reset_flush: got %b, required 0", fl); end
        idle(3);
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL post_reset_drain: got %0d pending, required 0", sb.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_beq_flush();
        test_compare();
        test_wrap();
        test_back_to_back();
        test_flush_squash();
        test_reset_midflush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of cycles younger instructions are squashed after a taken branch (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  upstream instruction valid.
REQ-005 in_ready  output  1  block can accept an instruction this cycle.
REQ-006 inst  input  32  instruction word.
REQ-007 pc  input  32  instruction address.
REQ-008 rs1_data  input  32  source operand 1.
REQ-009 rs2_data  input  32  source operand 2.
REQ-010 out_valid  output  1  resolved result valid.
REQ-011 out_ready  input  1  downstream (PC-select stage) accepts the result.
REQ-012 out_inst  output  32  registered copy of the accepted instruction.
REQ-013 out_taken  output  1  branch taken; this drives the PC-select stage's select input.
REQ-014 out_target  output  32  branch target (taken) or pc+4 (not taken / non-branch).
REQ-015 out_illegal  output  1  opcode 1100011 with funct3 010 or 011.
REQ-016 out_misalign  output  1  taken branch with out_target[1]=1.
REQ-017 flush  output  1  squash indication to the fetch/decode stages.

Function
REQ-018 Handshake: a transfer occurs when in_valid and in_ready are both 1; a result is consumed when out_valid and out_ready are both 1.
REQ-019 in_ready SHALL be (!out_valid || out_ready), independent of in_valid; during flush it follows the same rule.
REQ-020 One-entry output register; single-cycle latency: an instruction accepted in cycle N is presented with out_valid=1 in cycle N+1.
REQ-021 Full throughput: simultaneous consume and accept in the same cycle SHALL replace the output register with no bubble.
REQ-022 Output fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 Branch is opcode inst[6:0]=1100011; comparison by funct3: 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU.
REQ-024 Immediate: {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}, sign-extended to 32 bits; target = pc + imm modulo 2^32 (wrap-around, no overflow flag).
REQ-025 Non-branch or illegal funct3: out_taken=0, out_target=pc+4 modulo 2^32, out_misalign=0.
REQ-026 States: RUN (normal) and FLUSH; RUN->FLUSH in the cycle after a taken branch is accepted; FLUSH lasts exactly FLUSH_CYCLES cycles via down-counter, then ->RUN.
REQ-027 flush SHALL be 1 exactly while in FLUSH.
REQ-028 In FLUSH, accepted instructions SHALL be discarded (no out_valid produced); the taken branch itself is still presented normally.
REQ-029 A taken branch accepted while in FLUSH is squashed and SHALL NOT restart or extend the flush.
REQ-030 A held (stalled) taken result SHALL NOT delay flush entry.

Reset
REQ-031 While rst_n=0, all outputs SHALL be 0 and state SHALL be RUN with counter 0; in_ready SHALL be 1 immediately after release.
REQ-032 Reset asserted mid-flush or with a held result SHALL drop that result and end flush without completing it.

Structure
REQ-033 Branch opcode constant, funct3 encodings, and state enum SHALL reside in the shared package riscv_pkg.
REQ-034 The comparator SHALL be the combinational sub-module branch_cmp (inputs funct3, rs1, rs2; outputs taken, illegal).

Verification
REQ-035 BEQ, pc=0x100, rs1=rs2=5, imm=+16 -> next cycle out_taken=1, out_target=0x110, flush high 2 cycles.
REQ-036 BLT -1 vs 1 taken; BLTU 0xFFFFFFFF vs 1 not taken (out_target=pc+4).
REQ-037 pc=0xFFFFFFFC, taken imm=+8 -> out_target=0x00000004; non-branch at same pc -> out_target=0x00000000.
REQ-038 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; then out_ready=1 -> back-to-back accepts one per cycle.
REQ-039 Taken branch followed by 3 back-to-back instructions -> first 2 squashed (no out_valid), third presented; second taken branch within flush does not extend it.
REQ-040 rst_n=0 during flush cycle 1 -> flush=0, out_valid=0 immediately; after release, first instruction resolves normally.
